// File: rtl/cmt_pkg.sv
// -----------------------------------------------------------------------------
// cmt_pkg
// Shared constants for the cassette (CMT) data-path blocks.
//   - Avalon-MM word addresses of the input PIO register map
//   - EDGE_TYPE encodings that select which edges set the capture bits
//   - Bit positions of the status flags in the pulse-width register
// No ports: this file holds only a package.
// -----------------------------------------------------------------------------
package cmt_pkg;

  // Word addresses of the input PIO registers
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_PW   = 2'd3;

  // Which synchronized transitions set a capture bit
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Status flags in the pulse-width register; the width field sits at the bottom
  localparam int PW_VALID_BIT = 31;
  localparam int PW_OVR_BIT   = 30;

endpackage

// File: rtl/cmt_din_pio_if.sv
// -----------------------------------------------------------------------------
// cmt_din_pio_if
// Avalon-MM slave bus bundle for the CMT input PIO.
//   address    [1:0]  word address
//   chipselect        slave select
//   read              read strobe (only causes read side effects)
//   write_n           active-low write strobe, qualified by chipselect
//   writedata [31:0]  write data
//   readdata  [31:0]  registered read data from the slave
// Modports: master drives the request side, slave returns readdata.
// -----------------------------------------------------------------------------
interface cmt_din_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output read,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/cmt_din_sync.sv
// -----------------------------------------------------------------------------
// cmt_din_sync
// WIDTH x SYNC_STAGES flop synchronizer for asynchronous inputs. Every stage
// clears on reset, so the synchronized output is 0 straight after reset.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   i_d      asynchronous input bits
//   o_q      synchronized bits, SYNC_STAGES cycles behind i_d
// -----------------------------------------------------------------------------
module cmt_din_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  // Shift chain: stage 0 takes the raw pin, each later stage takes the one
  // before it; only the last stage is safe to use in the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/cmt_din_pio.sv
// -----------------------------------------------------------------------------
// cmt_din_pio
// Avalon-MM input PIO for the cassette data path. It synchronizes in_port,
// captures edges per bit behind an interrupt mask, and times the distance
// between bit-0 edges so software can measure tone periods without polling.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (address, chipselect, read, write_n, writedata,
//            readdata); readdata is registered with 1 cycle latency
//   in_port  asynchronous external inputs, WIDTH bits
//   irq      interrupt, high while any unmasked capture bit is set
// Register map: 0 DATA (RO), 1 MASK (RW), 2 EDGE (W1C), 3 PW (RO, read clears
// valid/overrun).
// -----------------------------------------------------------------------------
module cmt_din_pio
  import cmt_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  cmt_din_pio_if.slave     bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sd;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] w_edge_clr;
  logic             w_wr;
  logic             w_consume;
  logic             w_bit0_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] r_width;
  logic             r_valid;
  logic             r_ovr;
  logic [31:0]      w_rd_mux;
  logic [31:0]      r_readdata;
  logic             w_unused;

  cmt_din_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (in_port),
    .o_q     (w_s)
  );

  // One more flop behind the synchronizer gives the previous value for edge
  // detection. It resets to 0 like the synchronizer, so leaving reset never
  // looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sd <= '0;
    end else begin
      r_sd <= w_s;
    end
  end

  assign w_rise = w_s & ~r_sd;
  assign w_fall = ~w_s & r_sd;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_ev_rise
      assign w_ev = w_rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_ev_fall
      assign w_ev = w_fall;
    end else begin : g_ev_any
      assign w_ev = w_rise | w_fall;
    end
  endgenerate

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_consume   = bus.chipselect & bus.read & (bus.address == ADDR_PW);
  assign w_bit0_edge = w_s[0] ^ r_sd[0];
  assign w_edge_clr  = (w_wr && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

  // Only the low WIDTH bits of writedata land anywhere.
  assign w_unused = &{1'b0, bus.writedata};

  // Interrupt mask; writes to any other address leave it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr && (bus.address == ADDR_MASK)) begin
      r_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  // Edge capture: clear first, then OR in new events, so an event that lands
  // in the same cycle as its write-1-to-clear is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_ev;
    end
  end

  assign irq = |(r_edge & r_mask);

  // Saturating increment; also the width latched on an edge, because the
  // edge cycle itself counts toward the measured period.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // Pulse timer on bit 0. The counter restarts on every bit-0 edge and the
  // elapsed count is latched into width. Overrun flags a width lost before
  // software read it; a consuming read in the edge cycle counts as read, so
  // the fresh width comes up valid with no overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_width <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_cnt <= w_bit0_edge ? '0 : w_cnt_inc;
      if (w_bit0_edge) begin
        r_width <= w_cnt_inc;
        r_valid <= 1'b1;
        r_ovr   <= ~w_consume & (r_ovr | r_valid);
      end else if (w_consume) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  // Address mux over the current register state; unused bits stay 0.
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_s;
      ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge;
      ADDR_PW: begin
        w_rd_mux[PW_VALID_BIT] = r_valid;
        w_rd_mux[PW_OVR_BIT]   = r_ovr;
        w_rd_mux[CNT_W-1:0]    = r_width;
      end
      default: w_rd_mux = '0;
    endcase
  end

  // readdata reloads every cycle regardless of the strobes, giving the
  // fixed 1-cycle read latency the bus master expects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;

endmodule
